// File: rtl/chunk_adder.sv
// Multi-cycle adder: sums two WIDTH-bit operands CHUNK bits per clock,
// rippling the carry through a register between chunks.
module chunk_adder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("chunk_adder: WIDTH must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, cout_q;
  logic [CHUNK:0]   chunk_d;

  // Operands shift right each CALC cycle so the active chunk is always at bit 0.
  always_comb begin
    chunk_d = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + (CHUNK+1)'(carry_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            cnt_q   <= '0;
            state_q <= CALC;
          end
        end
        CALC: begin
          a_q     <= a_q >> CHUNK;
          b_q     <= b_q >> CHUNK;
          carry_q <= chunk_d[CHUNK];
          cnt_q   <= cnt_q + CW'(1);
          for (int unsigned i = 0; i < NCHUNK; i++) begin
            if (cnt_q == CW'(i)) sum_q[i*CHUNK +: CHUNK] <= chunk_d[CHUNK-1:0];
          end
          if (cnt_q == LAST) begin
            cout_q  <= chunk_d[CHUNK];
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_chunk_adder.sv
// Scoreboard bench for chunk_adder: three configurations (32/8, 4/1, 8/8)
// sharing one clock and reset.
module tb_chunk_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  // 32/8 instance
  logic        in_valid0 = 0, in_ready0, cin0 = 0, out_valid0, out_ready0 = 1, cout0;
  logic [31:0] a0 = '0, b0 = '0, sum0;
  // 4/1 instance
  logic        in_valid1 = 0, in_ready1, cin1 = 0, out_valid1, out_ready1 = 1, cout1;
  logic [3:0]  a1 = '0, b1 = '0, sum1;
  // 8/8 instance
  logic        in_valid2 = 0, in_ready2, cin2 = 0, out_valid2, out_ready2 = 1, cout2;
  logic [7:0]  a2 = '0, b2 = '0, sum2;

  chunk_adder #(.WIDTH(32), .CHUNK(8)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
    .a(a0), .b(b0), .cin(cin0), .out_valid(out_valid0), .out_ready(out_ready0),
    .sum(sum0), .cout(cout0));
  chunk_adder #(.WIDTH(4), .CHUNK(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1));
  chunk_adder #(.WIDTH(8), .CHUNK(8)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .cin(cin2), .out_valid(out_valid2), .out_ready(out_ready2),
    .sum(sum2), .cout(cout2));

  typedef struct {
    logic [63:0] exp;
    int unsigned acc;
  } sb_t;
  sb_t sb0[$], sb1[$], sb2[$];

  int unsigned n_checks = 0, n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Monitors: push expected on accept, check latency on out_valid rise, value on handshake.
  logic ov0_prev = 0, ov1_prev = 0, ov2_prev = 0;

  always @(negedge clk) begin
    sb_t e;
    if (rst_n) begin
      if (out_valid0 && !ov0_prev && sb0.size() != 0) check("lat0", 64'(cyc - sb0[0].acc), 64'd4);
      if (out_valid0 && out_ready0) begin
        check("pend0", 64'(sb0.size() != 0), 64'd1);
        if (sb0.size() != 0) begin
          e = sb0.pop_front();
          check("res0", 64'({cout0, sum0}), e.exp);
        end
      end
      if (in_valid0 && in_ready0)
        sb0.push_back('{exp: 64'(33'(a0) + 33'(b0) + 33'(cin0)), acc: cyc + 1});
    end
    ov0_prev = out_valid0;
  end

  always @(negedge clk) begin
    sb_t e;
    if (rst_n) begin
      if (out_valid1 && !ov1_prev && sb1.size() != 0) check("lat1", 64'(cyc - sb1[0].acc), 64'd4);
      if (out_valid1 && out_ready1) begin
        check("pend1", 64'(sb1.size() != 0), 64'd1);
        if (sb1.size() != 0) begin
          e = sb1.pop_front();
          check("res1", 64'({cout1, sum1}), e.exp);
        end
      end
      if (in_valid1 && in_ready1)
        sb1.push_back('{exp: 64'(5'(a1) + 5'(b1) + 5'(cin1)), acc: cyc + 1});
    end
    ov1_prev = out_valid1;
  end

  always @(negedge clk) begin
    sb_t e;
    if (rst_n) begin
      if (out_valid2 && !ov2_prev && sb2.size() != 0) check("lat2", 64'(cyc - sb2[0].acc), 64'd1);
      if (out_valid2 && out_ready2) begin
        check("pend2", 64'(sb2.size() != 0), 64'd1);
        if (sb2.size() != 0) begin
          e = sb2.pop_front();
          check("res2", 64'({cout2, sum2}), e.exp);
        end
      end
      if (in_valid2 && in_ready2)
        sb2.push_back('{exp: 64'(9'(a2) + 9'(b2) + 9'(cin2)), acc: cyc + 1});
    end
    ov2_prev = out_valid2;
  end

  function automatic logic rdy(input int i);
    case (i)
      0:       return in_ready0;
      1:       return in_ready1;
      default: return in_ready2;
    endcase
  endfunction

  function automatic int unsigned pending(input int i);
    case (i)
      0:       return sb0.size();
      1:       return sb1.size();
      default: return sb2.size();
    endcase
  endfunction

  // Wait for the edge that accepts the operands currently driven; returns its edge number.
  task automatic wait_acc(input int i, output int unsigned acc);
    int unsigned n = 0;
    @(negedge clk);
    while (!rdy(i) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", 64'(rdy(i)), 64'd1);
    acc = cyc + 1;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int i);
    int unsigned n = 0;
    while (pending(i) != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(pending(i)), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned acc, prev, r, n;
    logic [31:0] s_hold;
    logic        c_hold;

    // Reset state
    #12;
    check("rst_in_ready", 64'(in_ready0), 64'd1);
    check("rst_out_valid", 64'(out_valid0), 64'd0);
    check("rst_sum", 64'(sum0), 64'd0);
    check("rst_cout", 64'(cout0), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // All-ones wrap-around, latency 4
    a0 = 32'hFFFF_FFFF; b0 = 32'h0000_0001; cin0 = 0; in_valid0 = 1;
    wait_acc(0, acc);
    in_valid0 = 0;
    drain(0);
    check("wrap_result", 64'({cout0, sum0}), 64'h1_0000_0000);

    // Back-pressure in DONE with new operands waiting
    out_ready0 = 0;
    a0 = 32'hDEAD_BEEF; b0 = 32'h1234_5678; cin0 = 1; in_valid0 = 1;
    wait_acc(0, acc);
    a0 = 32'h0BAD_F00D; b0 = 32'h7777_7777; cin0 = 0;
    n = 0;
    @(negedge clk);
    while (!out_valid0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", 64'(out_valid0), 64'd1);
    s_hold = sum0;
    c_hold = cout0;
    check("stall_value", 64'({c_hold, s_hold}), 64'h0_F0E2_1568);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("stall_sum", 64'(sum0), 64'(s_hold));
      check("stall_cout", 64'(cout0), 64'(c_hold));
      check("stall_in_ready", 64'(in_ready0), 64'd0);
    end
    @(posedge clk);
    #1 out_ready0 = 1;
    r = cyc;
    wait_acc(0, acc);
    check("accept_after_ready", 64'(acc), 64'(r + 2));
    in_valid0 = 0;
    drain(0);

    // Reset in the middle of CALC
    a0 = 32'hAAAA_5555; b0 = 32'h5555_AAAA; cin0 = 1; in_valid0 = 1;
    wait_acc(0, acc);
    in_valid0 = 0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_out_valid", 64'(out_valid0), 64'd0);
    check("abort_sum", 64'(sum0), 64'd0);
    check("abort_cout", 64'(cout0), 64'd0);
    check("abort_in_ready", 64'(in_ready0), 64'd1);
    sb0.delete();
    a0 = 32'h1234_5678; b0 = 32'h0FED_CBA8; cin0 = 1; in_valid0 = 1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    r = cyc;
    wait_acc(0, acc);
    check("first_after_reset", 64'(acc), 64'(r + 1));
    in_valid0 = 0;
    drain(0);
    check("post_reset_result", 64'({cout0, sum0}), 64'h0_2222_2221);

    // Throughput: one accept every NCHUNK+2 cycles
    out_ready0 = 1;
    in_valid0  = 1;
    prev = 0;
    for (int k = 0; k < 20; k++) begin
      a0 = $urandom; b0 = $urandom; cin0 = 1'($urandom);
      wait_acc(0, acc);
      if (k > 0) check("period", 64'(acc - prev), 64'd6);
      prev = acc;
    end
    in_valid0 = 0;
    drain(0);

    // Exhaustive 4-bit, 1-bit chunks
    in_valid1 = 1;
    for (int unsigned v = 0; v < 512; v++) begin
      a1 = v[8:5]; b1 = v[4:1]; cin1 = v[0];
      wait_acc(1, acc);
    end
    in_valid1 = 0;
    drain(1);

    // Single-chunk configuration
    a2 = 8'h80; b2 = 8'h80; cin2 = 1; in_valid2 = 1;
    wait_acc(2, acc);
    in_valid2 = 0;
    drain(2);
    check("single_chunk", 64'({cout2, sum2}), 64'h101);
    a2 = 8'hFF; b2 = 8'hFF; cin2 = 1; in_valid2 = 1;
    wait_acc(2, acc);
    a2 = 8'h3C; b2 = 8'h41; cin2 = 0;
    wait_acc(2, acc);
    in_valid2 = 0;
    drain(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
